syst_ws_feeder: RTL and testbench

SYST_WS_FEEDER -- requirements
Module: syst_ws_feeder

---
 rtl/syst_pkg.sv | 21 ++
 rtl/syst_row_fifo.sv | 48 ++++
 rtl/syst_ws_feeder.sv | 129 ++++++++++++
 tb/tb_syst_ws_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/syst_pkg.sv
// syst_pkg: shared types for the weight-stationary activation feeder.
// Row layout, activation width and feeder FSM states.
package syst_pkg;

    localparam int COL     = 4;
    localparam int X_WIDTH = 8;

    typedef logic [X_WIDTH-1:0] x_t;

    typedef struct packed {
        logic             last;
        x_t [COL-1:0]     x;
    } row_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feed_state_t;

endpackage

// File: rtl/syst_row_fifo.sv
// syst_row_fifo: registered row buffer without fall-through.
// A row pushed on one edge is visible at the head from the next cycle on.
module syst_row_fifo #(
    parameter int  DEPTH = 4,
    parameter type row_t = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  row_t push_row,
    input  logic pop,
    output row_t pop_row,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    row_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_row;
    end

    assign pop_row = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/syst_ws_feeder.sv
// syst_ws_feeder: row FIFO, IDLE/STREAM/DRAIN control and lane skew chain.
// Define SYST_FEED_ZERO_FILL_EN to force skew data to 0 on bubbles.
module syst_ws_feeder #(
    parameter int COL        = 4,
    parameter int X_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [COL*X_WIDTH-1:0] s_data_i,
    input  logic                   s_last_i,
    output logic [X_WIDTH-1:0]     x1_o,
    output logic [X_WIDTH-1:0]     x2_o,
    output logic [X_WIDTH-1:0]     x3_o,
    output logic [X_WIDTH-1:0]     x4_o,
    output logic                   valid1_o,
    output logic                   valid2_o,
    output logic                   valid3_o,
    output logic                   valid4_o,
    output logic                   busy_o,
    output logic                   done_o
);

    import syst_pkg::*;

    localparam int CW = $clog2(COL);

    feed_state_t   state;
    logic [CW-1:0] drain_cnt;
    logic          done_q;
    logic          live_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    row_t          push_row;
    row_t          head;
    logic [COL-1:0] lane_v;
    x_t            lane_x [COL];

    assign push_row  = {s_last_i, s_data_i};
    // live_q keeps ready low for the cycle right after a reset edge
    assign s_ready_o = rst_i && live_q && !full && (state != DRAIN);
    assign push      = s_valid_i && s_ready_o;
    assign pop       = !empty && (state != DRAIN);

    syst_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .row_t (row_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_row (push_row),
        .pop      (pop),
        .pop_row  (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            done_q <= 1'b0;
            unique case (state)
                IDLE, STREAM: begin
                    drain_cnt <= '0;
                    if (pop) state <= head.last ? DRAIN : STREAM;
                end
                DRAIN: begin
                    if (drain_cnt == CW'(COL-1)) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // lane j sees its slice of the popped row after j+1 stages
    for (genvar j = 0; j < COL; j++) begin : g_lane
        logic [j:0] v_q;
        x_t   [j:0] d_q;

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                v_q <= '0;
                d_q <= '0;
            end else begin
                v_q[0] <= pop;
                for (int k = 1; k <= j; k++) v_q[k] <= v_q[k-1];
`ifdef SYST_FEED_ZERO_FILL_EN
                d_q[0] <= pop ? head.x[j] : '0;
                for (int k = 1; k <= j; k++)
                    d_q[k] <= v_q[k-1] ? d_q[k-1] : '0;
`else
                if (pop) d_q[0] <= head.x[j];
                for (int k = 1; k <= j; k++)
                    if (v_q[k-1]) d_q[k] <= d_q[k-1];
`endif
            end
        end

        assign lane_v[j] = v_q[j];
        assign lane_x[j] = d_q[j];
    end

    assign x1_o     = lane_x[0];
    assign x2_o     = lane_x[1];
    assign x3_o     = lane_x[2];
    assign x4_o     = lane_x[3];
    assign valid1_o = lane_v[0];
    assign valid2_o = lane_v[1];
    assign valid3_o = lane_v[2];
    assign valid4_o = lane_v[3];
    assign busy_o   = (state != IDLE);
    assign done_o   = done_q;

endmodule

// File: tb/tb_syst_ws_feeder.sv
// tb_syst_ws_feeder: directed rows, per-lane scoreboard queues and a
// negedge monitor checking order, skew, bubbles, done timing and reset.
module tb_syst_ws_feeder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_data_i;
    logic        s_last_i;
    logic [7:0]  x1_o, x2_o, x3_o, x4_o;
    logic        valid1_o, valid2_o, valid3_o, valid4_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    syst_ws_feeder dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .x1_o      (x1_o),
        .x2_o      (x2_o),
        .x3_o      (x3_o),
        .x4_o      (x4_o),
        .valid1_o  (valid1_o),
        .valid2_o  (valid2_o),
        .valid3_o  (valid3_o),
        .valid4_o  (valid4_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // per-lane expected {last, data}
    logic [8:0] sbq [4][$];
    int         done_cnt = 0;
    logic       chk_b2b  = 1'b0;
    logic       log_en   = 1'b0;
    logic       v1_log [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor
    logic       was_rst;
    logic [3:0] vv;
    logic [7:0] xs [4];
    logic [7:0] last_x [4];
    logic [3:1] v1h;
    logic       exp_done;
    logic       done_prev;
    logic [8:0] e;
    logic       got_last;

    initial begin : monitor
        exp_done  = 1'b0;
        done_prev = 1'b0;
        v1h       = '0;
        for (int j = 0; j < 4; j++) last_x[j] = '0;
        forever begin
            @(posedge clk);
            was_rst = !rst_i;
            @(negedge clk);
            vv    = {valid4_o, valid3_o, valid2_o, valid1_o};
            xs[0] = x1_o;
            xs[1] = x2_o;
            xs[2] = x3_o;
            xs[3] = x4_o;
            if (was_rst) begin
                for (int j = 0; j < 4; j++) begin
                    sbq[j].delete();
                    last_x[j] = '0;
                end
                v1h       = '0;
                exp_done  = 1'b0;
                done_prev = 1'b0;
                check("rst_valid", {28'd0, vv}, 32'd0);
                check("rst_x", {x4_o, x3_o, x2_o, x1_o}, 32'd0);
                check("rst_ready", {31'd0, s_ready_o}, 32'd0);
                check("rst_busy", {31'd0, busy_o}, 32'd0);
                check("rst_done", {31'd0, done_o}, 32'd0);
            end else begin
                for (int j = 1; j < 4; j++)
                    if (vv[j] || v1h[j])
                        check($sformatf("skew_l%0d", j), {31'd0, vv[j]},
                              {31'd0, v1h[j]});
                got_last = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (vv[j]) begin
                        if (sbq[j].size() == 0) begin
                            check($sformatf("extra_l%0d", j), {31'd0, vv[j]}, 32'd0);
                        end else begin
                            e = sbq[j].pop_front();
                            check($sformatf("data_l%0d", j), {24'd0, xs[j]},
                                  {24'd0, e[7:0]});
                            if (j == 3) got_last = e[8];
                        end
                        last_x[j] = xs[j];
                    end else begin
`ifdef SYST_FEED_ZERO_FILL_EN
                        check($sformatf("bubble_l%0d", j), {24'd0, xs[j]}, 32'd0);
`else
                        check($sformatf("hold_l%0d", j), {24'd0, xs[j]},
                              {24'd0, last_x[j]});
`endif
                    end
                end
                if (done_o || exp_done)
                    check("done_timing", {31'd0, done_o}, {31'd0, exp_done});
                if (done_o) done_cnt++;
                if (done_prev && chk_b2b) begin
                    check("b2b_pop", {31'd0, vv[0]}, 32'd1);
                    chk_b2b = 1'b0;
                end
                exp_done  = vv[3] && got_last;
                done_prev = done_o;
                v1h       = {v1h[2:1], vv[0]};
                if (log_en) v1_log.push_back(vv[0]);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic last, output int waits);
        waits = 0;
        @(negedge clk);
        s_valid_i = 1'b1;
        s_data_i  = {d, c, b, a};
        s_last_i  = last;
        while (!s_ready_o && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!s_ready_o) begin
            check("send_ready", {31'd0, s_ready_o}, 32'd1);
        end else begin
            sbq[0].push_back({last, a});
            sbq[1].push_back({last, b});
            sbq[2].push_back({last, c});
            sbq[3].push_back({last, d});
        end
        @(posedge clk);
        #1 s_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    int         w;
    int         n;
    int         base;
    int         stall;
    int         first;
    logic [4:0] pat;

    initial begin : stim
        rst_i     = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", {31'd0, s_ready_o}, 32'd1);
        check("busy_idle", {31'd0, busy_o}, 32'd0);

        // single row tile
        base = done_cnt;
        send(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, w);
        n = 0;
        while (!valid1_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lat_lane0", n, 2);
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lat_done", n, 6);
        check("busy_in_done", {31'd0, busy_o}, 32'd0);
        idle(5);
        check("done_single", done_cnt - base, 1);

        // six rows offered while a prior tile drains
        base  = done_cnt;
        stall = 0;
        send(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1, w);
        for (int i = 0; i < 6; i++) begin
            send(8'(32 + i), 8'(48 + i), 8'(64 + i), 8'(80 + i), i == 5, w);
            stall += w;
        end
        check("drain_stall", stall, 4);
        idle(30);
        check("done_stall", done_cnt - base, 2);

        // underrun: A, B, two-cycle gap, C
        base   = done_cnt;
        log_en = 1'b1;
        v1_log.delete();
        send(8'h11, 8'h12, 8'h13, 8'h14, 1'b0, w);
        send(8'h21, 8'h22, 8'h23, 8'h24, 1'b0, w);
        idle(2);
        send(8'h31, 8'h32, 8'h33, 8'h34, 1'b1, w);
        idle(20);
        log_en = 1'b0;
        first  = -1;
        for (int i = 0; i < v1_log.size(); i++)
            if (v1_log[i] && first < 0) first = i;
        pat = '0;
        for (int k = 0; k < 5; k++)
            if (first >= 0 && first + k < v1_log.size())
                pat = {pat[3:0], v1_log[first + k]};
        check("underrun_pattern", {27'd0, pat}, 32'b11001);
        check("done_underrun", done_cnt - base, 1);

        // back-to-back tiles
        base    = done_cnt;
        chk_b2b = 1'b1;
        send(8'h41, 8'h42, 8'h43, 8'h44, 1'b0, w);
        send(8'h51, 8'h52, 8'h53, 8'h54, 1'b0, w);
        send(8'h61, 8'h62, 8'h63, 8'h64, 1'b1, w);
        send(8'h71, 8'h72, 8'h73, 8'h74, 1'b0, w);
        send(8'h81, 8'h82, 8'h83, 8'h84, 1'b1, w);
        idle(30);
        check("done_b2b", done_cnt - base, 2);
        check("b2b_seen", {31'd0, chk_b2b}, 32'd0);

        // reset while lane 2 holds valid data
        base = done_cnt;
        send(8'h91, 8'h92, 8'h93, 8'h94, 1'b0, w);
        send(8'hB1, 8'hB2, 8'hB3, 8'hB4, 1'b0, w);
        send(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b0, w);
        n = 0;
        while (!valid3_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lane2_loaded", {31'd0, valid3_o}, 32'd1);
        rst_i = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_midrst", {31'd0, s_ready_o}, 32'd1);
        check("busy_after_midrst", {31'd0, busy_o}, 32'd0);
        idle(10);
        check("done_midrst", done_cnt - base, 0);

        // recovery tile
        base = done_cnt;
        send(8'h09, 8'h08, 8'h07, 8'h06, 1'b1, w);
        idle(15);
        check("done_recover", done_cnt - base, 1);

        for (int j = 0; j < 4; j++)
            check($sformatf("sb_empty_l%0d", j), sbq[j].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
